// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, control-field bit
// positions, multiply FSM encoding and the EX/MEM register layout.
// Latency: n/a (declarations only). Backpressure: n/a.
package ex_stage_pkg;

  localparam int XLEN = 32;

  // ALUOp encodings (EX_EX[2:0])
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_MUL   = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  // Bit positions inside the control bundles
  localparam int WB_REGWRITE = 1;  // EX_WB = {RegWrite, MemToReg}
  localparam int WB_MEMTOREG = 0;
  localparam int M_MEMREAD   = 1;  // EX_M  = {MemRead, MemWrite}
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 4;  // EX_EX = {RegDst, ALUSrc, ALUOp[2:0]}
  localparam int EX_ALUSRC   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic [1:0]      wb;
    logic [1:0]      m;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
  } exmem_t;

  // All-zero controls behave as a NOP downstream.
  localparam exmem_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b.
// Latency: one iteration per step cycle after start; done flags the last step.
// Backpressure: none; the owning FSM decides when to start, step or clear.
// Ports: start/a/b load operands, step advances one iteration, clear aborts,
//        done is high during the final iteration, product is the accumulator.
module ex_mul_seq import ex_stage_pkg::*; #(
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            clear,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(MUL_CYCLES);

  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (clear) begin
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      count_d  = '0;
    end else if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      count_d  = '0;
    end else if (step) begin
      // Only the low XLEN bits are kept, so the shifted-out multiplicand
      // bits never contribute to the result.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign done    = step && (count_q == CW'(MUL_CYCLES - 1));
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL, EX/MEM register.
// Latency: 1 cycle for ALU ops; MUL result lands on MEM_alu 34 cycles after presentation.
// Backpressure: stall held high while a MUL is pending or iterating; upstream holds ID/EX.
// Ports: EX_* are the ID/EX register outputs, WB_* the MEM/WB forwarding source,
//        ex_flush injects a bubble and aborts a MUL, MEM_* are the EX/MEM register.
module ex_stage import ex_stage_pkg::*; #(
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      EX_WB,
  input  logic [1:0]      EX_M,
  input  logic [4:0]      EX_EX,
  input  logic [XLEN-1:0] EX_SRC_A,
  input  logic [XLEN-1:0] EX_SRC_B,
  input  logic [XLEN-1:0] EX_SE,
  input  logic [4:0]      EX_rs,
  input  logic [4:0]      EX_rt,
  input  logic [4:0]      EX_rd,
  input  logic            WB_RegWrite,
  input  logic [4:0]      WB_rd,
  input  logic [XLEN-1:0] WB_data,
  input  logic            ex_flush,
  output logic            stall,
  output logic [1:0]      MEM_WB,
  output logic [1:0]      MEM_M,
  output logic [XLEN-1:0] MEM_alu,
  output logic [XLEN-1:0] MEM_wdata,
  output logic [4:0]      MEM_rd
);

  exmem_t          exmem_q, exmem_d;
  mul_state_e      state_q, state_d;

  logic [2:0]      alu_op;
  logic            alu_src;
  logic            reg_dst;
  logic            is_mul;
  logic            exmem_fwd_ok;
  logic            wb_fwd_ok;
  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic [4:0]      dest;
  logic            mul_start, mul_step, mul_done;
  logic [XLEN-1:0] mul_product;
  logic            stall_raw;

  assign alu_op  = EX_EX[EX_ALUOP_HI:EX_ALUOP_LO];
  assign alu_src = EX_EX[EX_ALUSRC];
  assign reg_dst = EX_EX[EX_REGDST];
  assign is_mul  = (alu_op == ALU_MUL);
  assign dest    = reg_dst ? EX_rd : EX_rt;

  // Loads in EX/MEM are never forwarded; load-use stalls happen upstream.
  assign exmem_fwd_ok = exmem_q.wb[WB_REGWRITE] && !exmem_q.m[M_MEMREAD] && (exmem_q.rd != 5'd0);
  assign wb_fwd_ok    = WB_RegWrite && (WB_rd != 5'd0);

  always_comb begin
    fwd_a = EX_SRC_A;
    if (exmem_fwd_ok && (exmem_q.rd == EX_rs)) begin
      fwd_a = exmem_q.alu;
    end else if (wb_fwd_ok && (WB_rd == EX_rs)) begin
      fwd_a = WB_data;
    end
    fwd_b = EX_SRC_B;
    if (exmem_fwd_ok && (exmem_q.rd == EX_rt)) begin
      fwd_b = exmem_q.alu;
    end else if (wb_fwd_ok && (WB_rd == EX_rt)) begin
      fwd_b = WB_data;
    end
  end

  assign alu_b = alu_src ? EX_SE : fwd_b;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:   alu_res = fwd_a + alu_b;
      ALU_SUB:   alu_res = fwd_a - alu_b;
      ALU_AND:   alu_res = fwd_a & alu_b;
      ALU_OR:    alu_res = fwd_a | alu_b;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      ALU_XOR:   alu_res = fwd_a ^ alu_b;
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = '0;  // MUL result comes from ex_mul_seq
    endcase
  end

  ex_mul_seq #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .step    (mul_step),
    .clear   (ex_flush),
    .a       (fwd_a),
    .b       (fwd_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (ex_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (is_mul)   state_d = ST_BUSY;
        ST_BUSY: if (mul_done) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;  // never re-arm on the same MUL
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and EX/MEM next value
  always_comb begin
    stall_raw = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    exmem_d   = EXMEM_BUBBLE;
    case (state_q)
      ST_IDLE: begin
        stall_raw = is_mul;
        mul_start = is_mul && !ex_flush;
        if (!is_mul) begin
          exmem_d = '{wb: EX_WB, m: EX_M, alu: alu_res, wdata: fwd_b, rd: dest};
        end
      end
      ST_BUSY: begin
        stall_raw = 1'b1;
        mul_step  = !ex_flush;
      end
      ST_DONE: begin
        // ID/EX is still holding the MUL, so its controls are current.
        exmem_d = '{wb: EX_WB, m: EX_M, alu: mul_product, wdata: fwd_b, rd: dest};
      end
      default: ;
    endcase
    if (ex_flush) begin
      exmem_d = EXMEM_BUBBLE;
    end
  end

  // Stall must read low while reset is held, even if ID/EX shows a MUL.
  assign stall = stall_raw && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_q <= EXMEM_BUBBLE;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign MEM_WB    = exmem_q.wb;
  assign MEM_M     = exmem_q.m;
  assign MEM_alu   = exmem_q.alu;
  assign MEM_wdata = exmem_q.wdata;
  assign MEM_rd    = exmem_q.rd;

endmodule
